// File: rtl/wb_arbiter_pkg.sv
// wb_pkg: shared Wishbone bus widths and the arbiter state encoding.
package wb_pkg;
    localparam int DataWidth = 32;
    localparam int AddrWidth = 32;
    localparam int SelWidth = DataWidth / 8;
    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_ABORT
    } wb_arb_state_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: per-master pipelined Wishbone request/response arrays plus the shared slave port.
interface wb_arbiter_if #(
    parameter int Count = 2,
    parameter int DataWidth = wb_pkg::DataWidth,
    parameter int AddrWidth = wb_pkg::AddrWidth
);
    localparam int SelWidth = DataWidth / 8;
    logic [DataWidth-1:0] m_data_m [Count];
    logic [AddrWidth-1:0] m_addr [Count];
    logic [SelWidth-1:0] m_sel [Count];
    logic [Count-1:0] m_cyc;
    logic [Count-1:0] m_stb;
    logic [Count-1:0] m_we;
    logic [DataWidth-1:0] m_data_s [Count];
    logic [Count-1:0] m_ack;
    logic [Count-1:0] m_stall;
    logic [Count-1:0] m_err;
    logic [DataWidth-1:0] s_data_m;
    logic [AddrWidth-1:0] s_addr;
    logic [SelWidth-1:0] s_sel;
    logic s_cyc;
    logic s_stb;
    logic s_we;
    logic [DataWidth-1:0] s_data_s;
    logic s_ack;
    logic s_stall;
    logic s_err;
    modport arbiter (
        input m_data_m, m_addr, m_sel, m_cyc, m_stb, m_we, s_data_s, s_ack, s_stall, s_err,
        output m_data_s, m_ack, m_stall, m_err, s_data_m, s_addr, s_sel, s_cyc, s_stb, s_we
    );
    modport master (
        output m_data_m, m_addr, m_sel, m_cyc, m_stb, m_we,
        input m_data_s, m_ack, m_stall, m_err
    );
    modport slave (
        input s_data_m, s_addr, s_sel, s_cyc, s_stb, s_we,
        output s_data_s, s_ack, s_stall, s_err
    );
endinterface

// File: rtl/wb_rr_picker.sv
// wb_rr_picker: combinational round-robin selector, first requester at or after i_ptr wins.
module wb_rr_picker #(
    parameter int Count = 2,
    localparam int IW = $clog2(Count)
) (
    input  logic [Count-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic             o_valid,
    output logic [IW-1:0]    o_idx
);
    localparam logic [IW:0] CntW = (IW + 1)'(Count);
    logic [Count-1:0] w_rot;
    logic [IW-1:0] w_off;
    logic [IW:0] w_sum;
    // Rotating by the pointer turns the search into a plain lowest-set-bit find.
    always_comb begin
        w_rot = Count'({i_req, i_req} >> i_ptr);
        w_off = '0;
        for (int k = Count - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = IW'(k);
        end
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        o_idx = (w_sum >= CntW) ? IW'(w_sum - CntW) : w_sum[IW-1:0];
        o_valid = |i_req;
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin sharing of one pipelined Wishbone slave among Count masters.
// Define WB_ARBITER_TIMEOUT_EN to add a watchdog that aborts cycles the slave never acknowledges.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int Count = 2,
    parameter int MaxOutstanding = 4,
    parameter int TimeoutCycles = 255
) (
    input logic clk,
    input logic reset,
    wb_arbiter_if.arbiter bus
);
    localparam int GW = $clog2(Count);
    localparam int OW = $clog2(MaxOutstanding + 1);

    wb_arb_state_t r_state, w_state_nxt;
    logic [GW-1:0] r_grant, w_grant_nxt, r_rr_ptr, w_rr_ptr_nxt, w_pick_idx, w_grant_inc;
    logic [OW-1:0] r_outstanding, w_outstanding_nxt;
    logic w_pick_valid, w_full, w_stb_g, w_acc, w_resp, w_timeout;

    wb_rr_picker #(.Count(Count)) u_picker (
        .i_req(bus.m_cyc),
        .i_ptr(r_rr_ptr),
        .o_valid(w_pick_valid),
        .o_idx(w_pick_idx)
    );

    assign w_full = r_outstanding == OW'(MaxOutstanding);
    assign w_stb_g = (r_state == ARB_GRANT) & bus.m_stb[r_grant] & ~w_full;
    assign w_acc = w_stb_g & ~bus.s_stall;
    assign w_resp = bus.s_ack | bus.s_err;
    assign w_grant_inc = (r_grant == GW'(Count - 1)) ? '0 : r_grant + 1'b1;

`ifdef WB_ARBITER_TIMEOUT_EN
    localparam int WW = $clog2(TimeoutCycles + 1);
    logic [WW-1:0] r_wdog, w_wdog_nxt;
    // Counts only while the slave owes us something: an accepted request or a stalled strobe.
    always_comb begin
        w_wdog_nxt = '0;
        w_timeout = 1'b0;
        if (r_state == ARB_GRANT && !w_resp && (r_outstanding != '0 || (w_stb_g && bus.s_stall))) begin
            w_timeout = r_wdog == WW'(TimeoutCycles - 1);
            w_wdog_nxt = r_wdog + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        r_wdog <= reset ? '0 : w_wdog_nxt;
    end
`else
    logic w_unused;
    assign w_unused = ^TimeoutCycles;
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        bus.s_data_m = '0;
        bus.s_addr = '0;
        bus.s_sel = '0;
        bus.s_cyc = 1'b0;
        bus.s_stb = 1'b0;
        bus.s_we = 1'b0;
        bus.m_stall = '1;
        bus.m_ack = '0;
        bus.m_err = '0;
        for (int i = 0; i < Count; i++) bus.m_data_s[i] = '0;
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_ptr_nxt = r_rr_ptr;
        w_outstanding_nxt = r_outstanding;
        case (r_state)
            ARB_IDLE: begin
                w_outstanding_nxt = '0;
                if (w_pick_valid) begin
                    w_state_nxt = ARB_GRANT;
                    w_grant_nxt = w_pick_idx;
                end
            end
            ARB_GRANT: begin
                bus.s_data_m = bus.m_data_m[r_grant];
                bus.s_addr = bus.m_addr[r_grant];
                bus.s_sel = bus.m_sel[r_grant];
                bus.s_cyc = bus.m_cyc[r_grant];
                bus.s_stb = w_stb_g;
                bus.s_we = bus.m_we[r_grant];
                bus.m_stall[r_grant] = bus.s_stall | w_full;
                bus.m_ack[r_grant] = bus.s_ack;
                bus.m_err[r_grant] = bus.s_err | w_timeout;
                bus.m_data_s[r_grant] = bus.s_data_s;
                w_outstanding_nxt = r_outstanding + OW'(w_acc) - OW'(w_resp);
                if (!bus.m_cyc[r_grant]) begin
                    w_state_nxt = ARB_IDLE;
                    w_rr_ptr_nxt = w_grant_inc;
                    w_outstanding_nxt = '0;
                end else if (w_timeout) begin
                    w_state_nxt = ARB_ABORT;
                end
            end
`ifdef WB_ARBITER_TIMEOUT_EN
            ARB_ABORT: begin
                if (!bus.m_cyc[r_grant]) begin
                    w_state_nxt = ARB_IDLE;
                    w_rr_ptr_nxt = w_grant_inc;
                    w_outstanding_nxt = '0;
                end
            end
`endif
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_rr_ptr <= '0;
            r_outstanding <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_outstanding <= w_outstanding_nxt;
        end
    end
endmodule
